sram_bridge_ctrl: RTL and testbench

Parametrised external asynchronous-SRAM controller that sits between the CPU general-purpose bus (IO_RD/IO_WR/IO_A/IO_BE/IO_DI/IO_Q/IO_READY style) and an off-chip SRAM. It generalises the 32-bit fixed-latency read-modify-write controller in these ways:
- data width is a parameter;
- native per-lane byte strobes are selectable as an alternative to RMW;
- writes can be posted (early acknowledge);
- a bus-turnaround cycle is guaranteed.

The tristate is split into out/oe/in so the top level owns the pad.

---
 rtl/sram_bridge_ctrl_pkg.sv | 29 ++
 rtl/sram_bridge_ctrl_if.sv | 33 +++
 rtl/sram_bridge_ctrl_lane_merge.sv | 23 ++
 rtl/sram_bridge_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_sram_bridge_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_bridge_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM bridge controller.
package sram_bridge_ctrl_pkg;

   // Latency counters are 3 bits wide; configured latencies saturate at 7.
   localparam int LCNT_W  = 3;
   localparam int MAX_LAT = 7;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_RMW_RD = 3'd2,
      S_WRITE  = 3'd3,
      S_TURN   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   // Number of byte lanes for a given data width.
   function automatic int lanes_of(input int data_w);
      return data_w / 8;
   endfunction

   // Convert a configured latency into a counter load value, saturating at MAX_LAT.
   function automatic logic [LCNT_W-1:0] clamp_lat(input int lat);
      if (lat > MAX_LAT) return LCNT_W'(MAX_LAT);
      if (lat < 0)       return '0;
      return LCNT_W'(lat);
   endfunction

endpackage

// File: rtl/sram_bridge_ctrl_if.sv
// CPU-side request/response bus of the SRAM bridge.
// Handshake: a requester raises req_rd or req_wr (never both) and holds it,
// together with req_addr/req_be/req_wdata, until ready pulses high for one
// cycle; rdata is valid while ready=1 and held until the next read completes.
// busy is high whenever the controller is not idle; requests are ignored then.
interface sram_bridge_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 19
);
   import sram_bridge_ctrl_pkg::*;

   localparam int LANES = lanes_of(DATA_W);

   logic              req_rd;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [LANES-1:0]  req_be;
   logic [DATA_W-1:0] req_wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              busy;

   modport master (
      output req_rd, req_wr, req_addr, req_be, req_wdata,
      input  rdata, ready, busy
   );

   modport slave (
      input  req_rd, req_wr, req_addr, req_be, req_wdata,
      output rdata, ready, busy
   );

endinterface

// File: rtl/sram_bridge_ctrl_lane_merge.sv
// Per-lane byte merge: lanes with be set take new_data, others keep old_data.
module sram_lane_merge
   import sram_bridge_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [lanes_of(DATA_W)-1:0] be,
   input  logic [DATA_W-1:0]           new_data,
   input  logic [DATA_W-1:0]           old_data,
   output logic [DATA_W-1:0]           merged
);

   localparam int LANES = lanes_of(DATA_W);

   // Byte mux, one lane at a time.
   always_comb begin
      merged = old_data;
      for (int i = 0; i < LANES; i++) begin
         if (be[i]) merged[8*i +: 8] = new_data[8*i +: 8];
      end
   end

endmodule

// File: rtl/sram_bridge_ctrl.sv
// External asynchronous SRAM controller. Every SRAM-side output comes straight
// from a flop; the pad tristate is split into dq_out/dq_oe/dq_in so the top
// level owns the bidirectional pin.
module sram_bridge_ctrl
   import sram_bridge_ctrl_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 19,
   parameter int RD_LATENCY = 1,
   parameter int WR_LATENCY = 1,
   parameter int NATIVE_BE  = 0,
   parameter int POSTED_WR  = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   sram_bridge_ctrl_if.slave           bus,
   output logic                        sram_cs_n,
   output logic                        sram_oe_n,
   output logic                        sram_we_n,
   output logic [lanes_of(DATA_W)-1:0] sram_be_n,
   output logic [ADDR_W-1:0]           sram_addr,
   output logic [DATA_W-1:0]           sram_dq_out,
   output logic                        sram_dq_oe,
   input  logic [DATA_W-1:0]           sram_dq_in,
   output state_t                      state_dbg
);

   localparam int               LANES    = lanes_of(DATA_W);
   localparam logic [LCNT_W-1:0] RD_LAT_C = clamp_lat(RD_LATENCY);
   localparam logic [LCNT_W-1:0] WR_LAT_C = clamp_lat(WR_LATENCY);

   state_t              state, state_nx;
   logic [LCNT_W-1:0]   lcount, lcount_nx;
   logic                cs_n, cs_n_nx;
   logic                oe_n, oe_n_nx;
   logic                we_n, we_n_nx;
   logic [LANES-1:0]    be_n, be_n_nx;
   logic [ADDR_W-1:0]   addr_q, addr_nx;
   logic [DATA_W-1:0]   dq_out_q, dq_out_nx;
   logic                dq_oe_q, dq_oe_nx;
   logic                ready_q, ready_nx;
   logic [DATA_W-1:0]   rdata_q, rdata_nx;
   // Write data and strobes captured at acceptance, so a posted RMW does not
   // depend on the requester holding req_* after the early acknowledge.
   logic [DATA_W-1:0]   wdata_q, wdata_nx;
   logic [LANES-1:0]    be_q, be_nx;
   logic [DATA_W-1:0]   merged;

   sram_lane_merge #(.DATA_W(DATA_W)) u_merge (
      .be       (be_q),
      .new_data (wdata_q),
      .old_data (sram_dq_in),
      .merged   (merged)
   );

   // State and output registers; reset aborts any cycle in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         lcount   <= '0;
         cs_n     <= 1'b1;
         oe_n     <= 1'b1;
         we_n     <= 1'b1;
         be_n     <= '1;
         addr_q   <= '0;
         dq_out_q <= '0;
         dq_oe_q  <= 1'b0;
         ready_q  <= 1'b0;
         rdata_q  <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
      end else begin
         state    <= state_nx;
         lcount   <= lcount_nx;
         cs_n     <= cs_n_nx;
         oe_n     <= oe_n_nx;
         we_n     <= we_n_nx;
         be_n     <= be_n_nx;
         addr_q   <= addr_nx;
         dq_out_q <= dq_out_nx;
         dq_oe_q  <= dq_oe_nx;
         ready_q  <= ready_nx;
         rdata_q  <= rdata_nx;
         wdata_q  <= wdata_nx;
         be_q     <= be_nx;
      end
   end

   // Next-state and next-output logic; every register holds unless a state says otherwise.
   always_comb begin
      state_nx  = state;
      lcount_nx = lcount;
      cs_n_nx   = cs_n;
      oe_n_nx   = oe_n;
      we_n_nx   = we_n;
      be_n_nx   = be_n;
      addr_nx   = addr_q;
      dq_out_nx = dq_out_q;
      dq_oe_nx  = dq_oe_q;
      ready_nx  = 1'b0;
      rdata_nx  = rdata_q;
      wdata_nx  = wdata_q;
      be_nx     = be_q;

      case (state)
         S_IDLE: begin
            if (bus.req_rd) begin
               // Read wins over a simultaneous write.
               state_nx  = S_READ;
               cs_n_nx   = 1'b0;
               oe_n_nx   = 1'b0;
               be_n_nx   = '0;
               lcount_nx = RD_LAT_C;
               addr_nx   = bus.req_addr;
            end else if (bus.req_wr) begin
               addr_nx  = bus.req_addr;
               wdata_nx = bus.req_wdata;
               be_nx    = bus.req_be;
               // Full, empty or natively strobed writes need no read phase.
               if (NATIVE_BE != 0 || (&bus.req_be) || !(|bus.req_be)) begin
                  state_nx  = S_WRITE;
                  cs_n_nx   = 1'b0;
                  we_n_nx   = 1'b0;
                  be_n_nx   = ~bus.req_be;
                  dq_out_nx = bus.req_wdata;
                  dq_oe_nx  = 1'b1;
                  lcount_nx = WR_LAT_C;
               end else begin
                  state_nx  = S_RMW_RD;
                  cs_n_nx   = 1'b0;
                  oe_n_nx   = 1'b0;
                  be_n_nx   = '0;
                  lcount_nx = RD_LAT_C;
               end
               if (POSTED_WR != 0) ready_nx = 1'b1;
            end
         end

         S_READ: begin
            if (lcount != '0) begin
               lcount_nx = lcount - 1'b1;
            end else begin
               rdata_nx = sram_dq_in;
               cs_n_nx  = 1'b1;
               oe_n_nx  = 1'b1;
               be_n_nx  = '1;
               ready_nx = 1'b1;
               state_nx = S_DONE;
            end
         end

         S_RMW_RD: begin
            if (lcount != '0) begin
               lcount_nx = lcount - 1'b1;
            end else begin
               dq_out_nx = merged;
               oe_n_nx   = 1'b1;
               we_n_nx   = 1'b0;
               be_n_nx   = '0;
               dq_oe_nx  = 1'b1;
               lcount_nx = WR_LAT_C;
               state_nx  = S_WRITE;
            end
         end

         S_WRITE: begin
            if (lcount != '0) begin
               lcount_nx = lcount - 1'b1;
            end else begin
               // WE rises and the pad is released on the same edge; TURN
               // then leaves the data bus undriven for a full cycle.
               we_n_nx  = 1'b1;
               cs_n_nx  = 1'b1;
               be_n_nx  = '1;
               dq_oe_nx = 1'b0;
               state_nx = S_TURN;
            end
         end

         S_TURN: begin
            dq_oe_nx = 1'b0;
            if (POSTED_WR != 0) begin
               state_nx = S_IDLE;
            end else begin
               ready_nx = 1'b1;
               state_nx = S_DONE;
            end
         end

         S_DONE: begin
            // One forced idle cycle so a request still held is not re-accepted.
            state_nx = S_IDLE;
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   assign sram_cs_n   = cs_n;
   assign sram_oe_n   = oe_n;
   assign sram_we_n   = we_n;
   assign sram_be_n   = be_n;
   assign sram_addr   = addr_q;
   assign sram_dq_out = dq_out_q;
   assign sram_dq_oe  = dq_oe_q;
   assign bus.rdata   = rdata_q;
   assign bus.ready   = ready_q;
   assign bus.busy    = (state != S_IDLE);
   assign state_dbg   = state;

endmodule

// File: tb/tb_sram_bridge_ctrl.sv
// Directed bench for sram_bridge_ctrl: three configurations (32-bit RMW,
// 32-bit native-strobe posted, 16-bit RMW with long write), each with a
// behavioural asynchronous SRAM built from an array.
module tb_sram_bridge_ctrl;
   import sram_bridge_ctrl_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- shared request drivers ----------------
   logic [1:0]  sel      = 2'd0;
   logic        req_rd_t = 1'b0;
   logic        req_wr_t = 1'b0;
   logic [18:0] addr_t   = '0;
   logic [3:0]  be_t     = '0;
   logic [31:0] wd_t     = '0;

   // ---------------- instance A: 32-bit, RMW, non-posted ----------------
   sram_bridge_ctrl_if #(.DATA_W(32), .ADDR_W(19)) a_bus ();
   logic        a_cs_n, a_oe_n, a_we_n, a_dq_oe;
   logic [3:0]  a_be_n;
   logic [18:0] a_addr;
   logic [31:0] a_dq_out, a_dq_in;
   state_t      a_state;
   logic [31:0] mem_a [0:255];

   assign a_bus.req_rd    = (sel == 2'd0) && req_rd_t;
   assign a_bus.req_wr    = (sel == 2'd0) && req_wr_t;
   assign a_bus.req_addr  = addr_t;
   assign a_bus.req_be    = be_t;
   assign a_bus.req_wdata = wd_t;

   sram_bridge_ctrl #(.DATA_W(32), .ADDR_W(19), .RD_LATENCY(1), .WR_LATENCY(1),
                      .NATIVE_BE(0), .POSTED_WR(0)) dut_a (
      .clk(clk), .rst(rst), .bus(a_bus.slave),
      .sram_cs_n(a_cs_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n), .sram_be_n(a_be_n),
      .sram_addr(a_addr), .sram_dq_out(a_dq_out), .sram_dq_oe(a_dq_oe),
      .sram_dq_in(a_dq_in), .state_dbg(a_state)
   );

   assign a_dq_in = (!a_cs_n && !a_oe_n) ? mem_a[a_addr[7:0]] : 32'hFFFF_FFFF;
   always @(posedge clk) begin
      if (!a_cs_n && !a_we_n && a_dq_oe)
         for (int i = 0; i < 4; i++)
            if (!a_be_n[i]) mem_a[a_addr[7:0]][8*i +: 8] <= a_dq_out[8*i +: 8];
   end

   // ---------------- instance B: 32-bit, native strobes, posted ----------------
   sram_bridge_ctrl_if #(.DATA_W(32), .ADDR_W(19)) b_bus ();
   logic        b_cs_n, b_oe_n, b_we_n, b_dq_oe;
   logic [3:0]  b_be_n;
   logic [18:0] b_addr;
   logic [31:0] b_dq_out, b_dq_in;
   state_t      b_state;
   logic [31:0] mem_b [0:255];

   assign b_bus.req_rd    = (sel == 2'd1) && req_rd_t;
   assign b_bus.req_wr    = (sel == 2'd1) && req_wr_t;
   assign b_bus.req_addr  = addr_t;
   assign b_bus.req_be    = be_t;
   assign b_bus.req_wdata = wd_t;

   sram_bridge_ctrl #(.DATA_W(32), .ADDR_W(19), .RD_LATENCY(1), .WR_LATENCY(1),
                      .NATIVE_BE(1), .POSTED_WR(1)) dut_b (
      .clk(clk), .rst(rst), .bus(b_bus.slave),
      .sram_cs_n(b_cs_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n), .sram_be_n(b_be_n),
      .sram_addr(b_addr), .sram_dq_out(b_dq_out), .sram_dq_oe(b_dq_oe),
      .sram_dq_in(b_dq_in), .state_dbg(b_state)
   );

   assign b_dq_in = (!b_cs_n && !b_oe_n) ? mem_b[b_addr[7:0]] : 32'hFFFF_FFFF;
   always @(posedge clk) begin
      if (!b_cs_n && !b_we_n && b_dq_oe)
         for (int i = 0; i < 4; i++)
            if (!b_be_n[i]) mem_b[b_addr[7:0]][8*i +: 8] <= b_dq_out[8*i +: 8];
   end

   // ---------------- instance C: 16-bit, RD 0, WR 3, RMW ----------------
   sram_bridge_ctrl_if #(.DATA_W(16), .ADDR_W(19)) c_bus ();
   logic        c_cs_n, c_oe_n, c_we_n, c_dq_oe;
   logic [1:0]  c_be_n;
   logic [18:0] c_addr;
   logic [15:0] c_dq_out, c_dq_in;
   state_t      c_state;
   logic [15:0] mem_c [0:255];

   assign c_bus.req_rd    = (sel == 2'd2) && req_rd_t;
   assign c_bus.req_wr    = (sel == 2'd2) && req_wr_t;
   assign c_bus.req_addr  = addr_t;
   assign c_bus.req_be    = be_t[1:0];
   assign c_bus.req_wdata = wd_t[15:0];

   sram_bridge_ctrl #(.DATA_W(16), .ADDR_W(19), .RD_LATENCY(0), .WR_LATENCY(3),
                      .NATIVE_BE(0), .POSTED_WR(0)) dut_c (
      .clk(clk), .rst(rst), .bus(c_bus.slave),
      .sram_cs_n(c_cs_n), .sram_oe_n(c_oe_n), .sram_we_n(c_we_n), .sram_be_n(c_be_n),
      .sram_addr(c_addr), .sram_dq_out(c_dq_out), .sram_dq_oe(c_dq_oe),
      .sram_dq_in(c_dq_in), .state_dbg(c_state)
   );

   assign c_dq_in = (!c_cs_n && !c_oe_n) ? mem_c[c_addr[7:0]] : 16'hFFFF;
   always @(posedge clk) begin
      if (!c_cs_n && !c_we_n && c_dq_oe)
         for (int i = 0; i < 2; i++)
            if (!c_be_n[i]) mem_c[c_addr[7:0]][8*i +: 8] <= c_dq_out[8*i +: 8];
   end

   // ---------------- view of the selected instance ----------------
   logic        cur_ready, cur_busy, cur_cs_n, cur_oe_n, cur_we_n, cur_dq_oe;
   logic [3:0]  cur_be_n;
   logic [18:0] cur_addr;
   logic [31:0] cur_rdata, cur_dq_out;
   state_t      cur_state;

   always_comb begin
      cur_ready  = a_bus.ready;
      cur_busy   = a_bus.busy;
      cur_rdata  = a_bus.rdata;
      cur_cs_n   = a_cs_n;
      cur_oe_n   = a_oe_n;
      cur_we_n   = a_we_n;
      cur_be_n   = a_be_n;
      cur_dq_oe  = a_dq_oe;
      cur_addr   = a_addr;
      cur_dq_out = a_dq_out;
      cur_state  = a_state;
      if (sel == 2'd1) begin
         cur_ready  = b_bus.ready;
         cur_busy   = b_bus.busy;
         cur_rdata  = b_bus.rdata;
         cur_cs_n   = b_cs_n;
         cur_oe_n   = b_oe_n;
         cur_we_n   = b_we_n;
         cur_be_n   = b_be_n;
         cur_dq_oe  = b_dq_oe;
         cur_addr   = b_addr;
         cur_dq_out = b_dq_out;
         cur_state  = b_state;
      end else if (sel == 2'd2) begin
         cur_ready  = c_bus.ready;
         cur_busy   = c_bus.busy;
         cur_rdata  = {16'h0000, c_bus.rdata};
         cur_cs_n   = c_cs_n;
         cur_oe_n   = c_oe_n;
         cur_we_n   = c_we_n;
         cur_be_n   = {2'b11, c_be_n};
         cur_dq_oe  = c_dq_oe;
         cur_addr   = c_addr;
         cur_dq_out = {16'h0000, c_dq_out};
         cur_state  = c_state;
      end
   end

   // A read and a write must never be requested together.
   always @(negedge clk) begin
      if (!rst) assert (!(req_rd_t && req_wr_t)) else begin
         errors++;
         $error("FAIL proto_rd_wr observed=1 expected=0");
      end
   end

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int          lat, we_cyc, oe_cyc;
   logic        turn_oe, we_hold;
   logic [3:0]  be_we;
   logic [31:0] rd_v, rd_v2;
   int          n, t1, t2;
   logic        busy_at;

   task automatic wait_idle();
      int k;
      k = 0;
      while (cur_busy && k < 50) begin
         @(negedge clk);
         k++;
      end
   endtask

   // One transfer on the selected instance; records latency (cycles from the
   // accepting edge to the ready cycle) and pin activity until it is idle again.
   task automatic xfer(input bit wr, input logic [18:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
      int k;
      wait_idle();
      req_rd_t = !wr;
      req_wr_t = wr;
      addr_t   = addr;
      be_t     = be;
      wd_t     = wd;
      lat = 0; we_cyc = 0; oe_cyc = 0;
      turn_oe = 1'b1; we_hold = 1'b1; be_we = 4'hF; rd_v = '0;
      k = 0;
      while (k < 60) begin
         @(negedge clk);
         k++;
         if (!cur_we_n) begin
            we_cyc++;
            be_we = cur_be_n;
            if (!cur_dq_oe) we_hold = 1'b0;
         end
         if (!cur_oe_n) oe_cyc++;
         if (cur_state == S_TURN) turn_oe = cur_dq_oe;
         if (cur_ready && lat == 0) begin
            lat      = k;
            rd_v     = cur_rdata;
            req_rd_t = 1'b0;
            req_wr_t = 1'b0;
         end
         if (lat != 0 && !cur_busy) break;
      end
      req_rd_t = 1'b0;
      req_wr_t = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset values on every instance.
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         chk($sformatf("rst_ctl_%0d", s),
             64'({cur_cs_n, cur_oe_n, cur_we_n, cur_be_n, cur_dq_oe, cur_ready, cur_busy}),
             64'({3'b111, 4'hF, 3'b000}));
         chk($sformatf("rst_data_%0d", s), {cur_rdata, cur_dq_out}, 64'd0);
         chk($sformatf("rst_addr_%0d", s), 64'(cur_addr), 64'd0);
      end

      // ----- A: full write, read back, RMW, empty-strobe write -----
      sel = 2'd0;
      #1;
      xfer(1'b1, 19'h00010, 4'hF, 32'hDEADBEEF);
      chk("a_wr_lat", 64'(lat), 64'd4);
      chk("a_wr_we_cycles", 64'(we_cyc), 64'd2);
      chk("a_wr_no_oe", 64'(oe_cyc), 64'd0);
      chk("a_wr_turn_dq_oe", 64'(turn_oe), 64'd0);
      chk("a_wr_dq_hold", 64'(we_hold), 64'd1);
      chk("a_wr_mem", 64'(mem_a[8'h10]), 64'hDEADBEEF);

      xfer(1'b0, 19'h00010, 4'hF, 32'h0);
      chk("a_rd_lat", 64'(lat), 64'd3);
      chk("a_rd_data", 64'(rd_v), 64'hDEADBEEF);
      chk("a_rd_oe_cycles", 64'(oe_cyc), 64'd2);
      chk("a_rd_no_we", 64'(we_cyc), 64'd0);

      xfer(1'b1, 19'h00020, 4'hF, 32'h11223344);
      xfer(1'b1, 19'h00020, 4'b0100, 32'h00AA0000);
      chk("a_rmw_lat", 64'(lat), 64'd6);
      chk("a_rmw_oe_cycles", 64'(oe_cyc), 64'd2);
      chk("a_rmw_we_cycles", 64'(we_cyc), 64'd2);
      chk("a_rmw_be_n", 64'(be_we), 64'h0);
      chk("a_rmw_mem", 64'(mem_a[8'h20]), 64'h11AA3344);

      xfer(1'b0, 19'h00020, 4'hF, 32'h0);
      chk("a_rmw_readback", 64'(rd_v), 64'h11AA3344);

      xfer(1'b1, 19'h00020, 4'h0, 32'hFFFFFFFF);
      chk("a_be0_lat", 64'(lat), 64'd4);
      chk("a_be0_no_oe", 64'(oe_cyc), 64'd0);
      chk("a_be0_be_n", 64'(be_we), 64'hF);
      chk("a_be0_mem", 64'(mem_a[8'h20]), 64'h11AA3344);

      // ----- B: native strobes, posted writes -----
      sel = 2'd1;
      #1;
      xfer(1'b1, 19'h00020, 4'hF, 32'h11223344);
      chk("b_full_lat", 64'(lat), 64'd1);
      xfer(1'b1, 19'h00020, 4'b0100, 32'h00AA0000);
      chk("b_native_lat", 64'(lat), 64'd1);
      chk("b_native_be_n", 64'(be_we), 64'b1011);
      chk("b_native_no_oe", 64'(oe_cyc), 64'd0);
      chk("b_native_we_cycles", 64'(we_cyc), 64'd2);
      chk("b_native_mem", 64'(mem_b[8'h20]), 64'h11AA3344);

      // Posted write, then a read raised in the acknowledge cycle and held.
      wait_idle();
      req_rd_t = 1'b0;
      req_wr_t = 1'b1;
      addr_t   = 19'h00030;
      be_t     = 4'hF;
      wd_t     = 32'hCAFEF00D;
      t1 = 0; t2 = 0; busy_at = 1'b0; rd_v = '0; n = 0;
      while (n < 60 && t2 == 0) begin
         @(negedge clk);
         n++;
         if (cur_ready) begin
            if (t1 == 0) begin
               t1       = n;
               busy_at  = cur_busy;
               req_wr_t = 1'b0;
               req_rd_t = 1'b1;
            end else begin
               t2       = n;
               rd_v     = cur_rdata;
               req_rd_t = 1'b0;
            end
         end
      end
      req_rd_t = 1'b0;
      chk("b_posted_ack", 64'(t1), 64'd1);
      chk("b_posted_busy", 64'(busy_at), 64'd1);
      chk("b_posted_rd_ready", 64'(t2), 64'd7);
      chk("b_posted_rd_data", 64'(rd_v), 64'hCAFEF00D);

      // ----- C: 16-bit, RD 0, WR 3 -----
      sel = 2'd2;
      #1;
      wait_idle();
      xfer(1'b1, 19'h00005, 4'h3, 32'h00001234);
      chk("c_wr_lat", 64'(lat), 64'd6);
      chk("c_wr_we_cycles", 64'(we_cyc), 64'd4);
      xfer(1'b1, 19'h00006, 4'h3, 32'h0000BEEF);
      chk("c_wr2_we_cycles", 64'(we_cyc), 64'd4);
      chk("c_wr2_mem", 64'(mem_c[8'h06]), 64'hBEEF);

      // Held read request: second read is accepted only after DONE.
      wait_idle();
      req_wr_t = 1'b0;
      req_rd_t = 1'b1;
      addr_t   = 19'h00005;
      t1 = 0; t2 = 0; rd_v = '0; rd_v2 = '0; n = 0;
      while (n < 60 && t2 == 0) begin
         @(negedge clk);
         n++;
         if (cur_ready) begin
            if (t1 == 0) begin
               t1     = n;
               rd_v   = cur_rdata;
               addr_t = 19'h00006;
            end else begin
               t2       = n;
               rd_v2    = cur_rdata;
               req_rd_t = 1'b0;
            end
         end
      end
      req_rd_t = 1'b0;
      chk("c_b2b_first", 64'(t1), 64'd2);
      chk("c_b2b_second", 64'(t2), 64'd5);
      chk("c_b2b_data0", 64'(rd_v), 64'h1234);
      chk("c_b2b_data1", 64'(rd_v2), 64'hBEEF);

      xfer(1'b1, 19'h00005, 4'b0001, 32'h000000CD);
      chk("c_rmw_lat", 64'(lat), 64'd7);
      chk("c_rmw_mem", 64'(mem_c[8'h05]), 64'h12CD);

      // Reset while WRITE still has two wait cycles left.
      wait_idle();
      req_rd_t = 1'b0;
      req_wr_t = 1'b1;
      addr_t   = 19'h00007;
      be_t     = 4'h3;
      wd_t     = 32'h00005555;
      @(negedge clk);
      @(negedge clk);
      chk("c_rstw_state", 64'(cur_state), 64'(S_WRITE));
      chk("c_rstw_we_low", 64'(cur_we_n), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("c_rstw_pins",
          64'({cur_cs_n, cur_oe_n, cur_we_n, cur_be_n, cur_dq_oe, cur_ready, cur_busy}),
          64'({3'b111, 4'hF, 3'b000}));
      chk("c_rstw_idle", 64'(cur_state), 64'(S_IDLE));
      req_wr_t = 1'b0;
      rst      = 1'b0;
      t1 = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (cur_ready) t1++;
      end
      chk("c_rstw_no_ready", 64'(t1), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
